// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {CLEAR, READY} state_e;

  // Number of byte-offset bits inside one memory word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store shift + byte enables, and load extract with sign/zero extension.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                     size_i,
  input  logic [lane_bits(DATA_W)-1:0]   off_i,
  input  logic                           uns_i,
  input  logic [DATA_W-1:0]              wdata_i,
  input  logic [DATA_W-1:0]              rword_i,
  output logic [DATA_W/8-1:0]            be_o,
  output logic [DATA_W-1:0]              wdata_o,
  output logic [DATA_W-1:0]              rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [3:0]        nbytes;
  logic [DATA_W-1:0] rsh;
  logic              sign;

  always_comb begin
    nbytes  = 4'd1 << size_i;
    be_o    = '0;
    for (int b = 0; b < NB; b++)
      if (b >= int'(off_i) && b < int'(off_i) + int'(nbytes)) be_o[b] = 1'b1;
    wdata_o = wdata_i << {off_i, 3'b000};
    rsh     = rword_i >> {off_i, 3'b000};
    // Sign bit is the top bit of the accessed field; suppressed for unsigned loads.
    sign    = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == 8 * int'(nbytes) - 1) sign = rsh[i] & ~uns_i;
    rdata_o = '0;
    for (int i = 0; i < DATA_W; i++)
      rdata_o[i] = (i < 8 * int'(nbytes)) ? rsh[i] : sign;
  end

endmodule

// File: rtl/dmem_unit.sv
// Parametrised MEM-stage data memory with byte/half/word/dword access and post-reset clear.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of aligning down.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int NB = DATA_W / 8;
  localparam int LB = lane_bits(DATA_W);
  localparam int IW = $clog2(DEPTH);

  state_e            state_q;
  logic [IW-1:0]     clr_cnt_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_fault_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     idx;
  logic [LB-1:0]     off_raw, off_eff, lo_mask;
  logic [1:0]        sz_eff;
  logic              misalign, fault, accept, st_we;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh, ld_data;
  logic              unused_addr;

  assign idx         = req_addr[LB+IW-1:LB];
  assign off_raw     = req_addr[LB-1:0];
  assign unused_addr = ^req_addr;

  // A dword on a 32-bit array is handled as a word for lane steering.
  assign sz_eff   = (DATA_W == 32 && req_size == SZ_D) ? SZ_W : req_size;
  assign lo_mask  = LB'((4'd1 << sz_eff) - 4'd1);
  assign misalign = |(off_raw & lo_mask);
  assign off_eff  = off_raw & ~lo_mask;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = misalign || (DATA_W == 32 && req_size == SZ_D);
`else
  assign fault = 1'b0;
`endif

  assign accept = req_valid & ready_q;
  assign st_we  = accept & req_we & ~fault;

  dmem_align #(.DATA_W(DATA_W)) u_align (
    .size_i  (sz_eff),
    .off_i   (off_eff),
    .uns_i   (req_unsigned),
    .wdata_i (req_wdata),
    .rword_i (mem[idx]),
    .be_o    (be),
    .wdata_o (wdata_sh),
    .rdata_o (ld_data)
  );

  // Array has no reset; the clear sequencer zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q   <= clr_cnt_q + IW'(1);
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_fault_q <= 1'b0;
          if (clr_cnt_q == IW'(DEPTH - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          rsp_valid_q <= accept;
          rsp_fault_q <= accept & fault;
          rsp_rdata_q <= (accept & ~req_we & ~fault) ? ld_data : '0;
        end
        default: begin
          state_q <= CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
